au_cmd_driver: RTL and testbench



---
 rtl/kf_au_pkg.sv | 30 +++
 rtl/au_cmd_driver_if.sv | 54 +++++
 rtl/au_cmd_driver.sv | 98 +++++++++
 tb/tb_au_cmd_driver.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kf_au_pkg.sv
// Shared definitions for the Kalman-filter arithmetic-unit command path:
// data format, AU op encodings, driver FSM states and saturation constant.
package kf_au_pkg;

    // S9.14 sign-magnitude data word
    localparam int unsigned W    = 24;
    localparam int unsigned FRAC = 14;

    // AU op_sel / mul_y_sel encodings
    localparam logic [1:0] OP_DIV     = 2'b11;
    localparam logic [1:0] YSEL_RECIP = 2'b10;

    // Largest magnitude representable; sign bit is supplied separately
    localparam logic [W-2:0] SAT_MAG = {(W - 1){1'b1}};

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } au_drv_state_e;

    // Division whose divisor magnitude is zero (either sign of zero)
    function automatic logic is_div_zero(input logic [1:0]   op,
                                         input logic [1:0]   ysel,
                                         input logic [W-1:0] s);
        return (op == OP_DIV) && (ysel == YSEL_RECIP) && (s[W-2:0] == '0);
    endfunction

endpackage

// File: rtl/au_cmd_driver_if.sv
// Bundle of the command, AU and response ports of au_cmd_driver.
// master: the driver itself. slave: the surrounding sequencer/AU side.
interface au_cmd_driver_if #(
    parameter int unsigned W     = kf_au_pkg::W,
    parameter int unsigned TAG_W = 4
);

    // Command port (sequencer -> driver)
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [1:0]       cmd_ysel;
    logic [W-1:0]     cmd_r;
    logic [W-1:0]     cmd_s;
    logic [W-1:0]     cmd_imm;
    logic [TAG_W-1:0] cmd_tag;

    // AU start/done handshake
    logic             au_start;
    logic [W-1:0]     au_R;
    logic [W-1:0]     au_S;
    logic [W-1:0]     au_Iimm;
    logic [1:0]       au_op_sel;
    logic [1:0]       au_mul_y_sel;
    logic [W-1:0]     au_result;
    logic             au_done;
    logic             au_busy;

    // Response port (driver -> sequencer)
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;

    modport master (
        input  cmd_valid, cmd_op, cmd_ysel, cmd_r, cmd_s, cmd_imm, cmd_tag,
        input  au_result, au_done, au_busy,
        input  rsp_ready,
        output cmd_ready,
        output au_start, au_R, au_S, au_Iimm, au_op_sel, au_mul_y_sel,
        output rsp_valid, rsp_data, rsp_tag, rsp_err
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_ysel, cmd_r, cmd_s, cmd_imm, cmd_tag,
        output au_result, au_done, au_busy,
        output rsp_ready,
        input  cmd_ready,
        input  au_start, au_R, au_S, au_Iimm, au_op_sel, au_mul_y_sel,
        input  rsp_valid, rsp_data, rsp_tag, rsp_err
    );

endinterface

// File: rtl/au_cmd_driver.sv
// Initiator side of the AU start/done handshake. Takes one command at a time,
// holds its operands on the AU inputs, pulses start, waits for done with a
// timeout and returns the result with the command tag.
// Optional feature: define AU_DRV_DIVZERO_CHECK_EN to answer divide-by-zero
// commands locally with a saturated, error-flagged result and no AU start.
module au_cmd_driver
    import kf_au_pkg::*;
#(
    parameter int unsigned TIMEOUT = 100
) (
    input logic             clk,
    input logic             rst_n,
    au_cmd_driver_if.master bus
);

    // Counter must be able to hold TIMEOUT itself
    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT);

    au_drv_state_e   state_q;
    logic [CntW-1:0] wait_cnt_q;

    // Handshake outputs decoded from state; start also honours a busy AU
    always_comb begin
        bus.cmd_ready = (state_q == StIdle);
        bus.rsp_valid = (state_q == StResp);
        bus.au_start  = (state_q == StIssue) && !bus.au_busy;
    end

    // FSM, timeout counter and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            wait_cnt_q       <= '0;
            bus.au_R         <= '0;
            bus.au_S         <= '0;
            bus.au_Iimm      <= '0;
            bus.au_op_sel    <= '0;
            bus.au_mul_y_sel <= '0;
            bus.rsp_data     <= '0;
            bus.rsp_tag      <= '0;
            bus.rsp_err      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        bus.au_R         <= bus.cmd_r;
                        bus.au_S         <= bus.cmd_s;
                        bus.au_Iimm      <= bus.cmd_imm;
                        bus.au_op_sel    <= bus.cmd_op;
                        bus.au_mul_y_sel <= bus.cmd_ysel;
                        bus.rsp_tag      <= bus.cmd_tag;
`ifdef AU_DRV_DIVZERO_CHECK_EN
                        if (is_div_zero(bus.cmd_op, bus.cmd_ysel, bus.cmd_s)) begin
                            // Saturate with the dividend's sign, never bother the AU
                            bus.rsp_data <= {bus.cmd_r[W-1], SAT_MAG};
                            bus.rsp_err  <= 1'b1;
                            state_q      <= StResp;
                        end else begin
                            state_q <= StIssue;
                        end
`else
                        state_q <= StIssue;
`endif
                    end
                end
                StIssue: begin
                    // Start is visible combinationally this cycle when not busy
                    if (!bus.au_busy) begin
                        wait_cnt_q <= '0;
                        state_q    <= StWait;
                    end
                end
                StWait: begin
                    // done wins over timeout in the final counted cycle
                    if (bus.au_done) begin
                        bus.rsp_data <= bus.au_result;
                        bus.rsp_err  <= 1'b0;
                        state_q      <= StResp;
                    end else if (wait_cnt_q == CntLast) begin
                        bus.rsp_data <= '0;
                        bus.rsp_err  <= 1'b1;
                        state_q      <= StResp;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CntW'(1);
                    end
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_au_cmd_driver.sv
// Scoreboard bench for au_cmd_driver: directed commands push hand-computed
// responses, a monitor pops and compares on every response handshake, and a
// small AU model answers start pulses after a programmable latency.
module tb_au_cmd_driver;
    import kf_au_pkg::*;

    localparam int unsigned TAG_W   = 4;
    localparam int unsigned TIMEOUT = 100;

    typedef struct packed {
        logic [W-1:0]     data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    au_cmd_driver_if #(.W(W), .TAG_W(TAG_W)) bus ();

    au_cmd_driver #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   tests = 0;
    int   fails = 0;
    rsp_t exp_q[$];

    // AU model state plus a separate injection path for stray done pulses
    int           model_lat = 1;
    logic [W-1:0] model_res = '0;
    logic         model_done = 1'b0;
    logic [W-1:0] model_out = '0;
    logic         inj_done = 1'b0;
    logic [W-1:0] inj_res = '0;
    int           start_cnt = 0;

    assign bus.au_done   = model_done | inj_done;
    assign bus.au_result = inj_done ? inj_res : model_out;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void sb_push(input logic [W-1:0] data, input logic [TAG_W-1:0] tag,
                                    input logic err);
        rsp_t e;
        e.data = data;
        e.tag  = tag;
        e.err  = err;
        exp_q.push_back(e);
    endfunction

    // AU model: done for one cycle, model_lat cycles after the start cycle
    initial begin : au_model
        forever begin
            @(negedge clk);
            if (bus.au_start) begin
                start_cnt++;
                if (model_lat > 0) begin
                    repeat (model_lat) @(posedge clk);
                    #1;
                    model_done = 1'b1;
                    model_out  = model_res;
                    @(posedge clk);
                    #1;
                    model_done = 1'b0;
                    model_out  = '0;
                end
            end
        end
    end

    // Monitor: every response handshake is compared against the queue head
    initial begin : monitor
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rsp_unexpected: got data 0x%0h tag %0d err %0b, expected none",
                             bus.rsp_data, bus.rsp_tag, bus.rsp_err);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                    check("rsp_tag", 32'(bus.rsp_tag), 32'(e.tag));
                    check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                end
            end
        end
    end

    task automatic check_cleared(input string name);
        check({name, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        check({name, "_au_start"}, 32'(bus.au_start), 32'd0);
        check({name, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({name, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
        check({name, "_rsp_tag"}, 32'(bus.rsp_tag), 32'd0);
        check({name, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
        check({name, "_au_R"}, 32'(bus.au_R), 32'd0);
        check({name, "_au_S"}, 32'(bus.au_S), 32'd0);
        check({name, "_au_Iimm"}, 32'(bus.au_Iimm), 32'd0);
        check({name, "_au_op"}, 32'({bus.au_op_sel, bus.au_mul_y_sel}), 32'd0);
    endtask

    // Offer a command and return one posedge+1 after it was accepted
    task automatic send(input logic [1:0] op, input logic [1:0] ysel, input logic [W-1:0] r,
                        input logic [W-1:0] s, input logic [W-1:0] imm,
                        input logic [TAG_W-1:0] tag);
        int n = 0;
        @(posedge clk);
        #1;
        bus.cmd_op    = op;
        bus.cmd_ysel  = ysel;
        bus.cmd_r     = r;
        bus.cmd_s     = s;
        bus.cmd_imm   = imm;
        bus.cmd_tag   = tag;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        while (!bus.cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            tests++;
            fails++;
            $display("FAIL cmd_accept: got cmd_ready 0 after %0d cycles, expected 1", n);
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Count negedges (first is the accept+1 cycle) until rsp_valid
    task automatic wait_rsp(output int lat, output int start_at);
        lat      = 0;
        start_at = 0;
        while (lat < 400) begin
            @(negedge clk);
            lat++;
            if (bus.au_start && start_at == 0) start_at = lat;
            if (bus.rsp_valid) break;
        end
        if (!bus.rsp_valid) begin
            tests++;
            fails++;
            $display("FAIL rsp_wait: got no rsp_valid in %0d cycles, expected one", lat);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || !bus.cmd_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            tests++;
            fails++;
            $display("FAIL %s_drain: got %0d pending responses, expected 0", name, exp_q.size());
        end
    endtask

    initial begin : stim
        int lat;
        int st;
        int starts_before;
        int n;

        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_ysel  = '0;
        bus.cmd_r     = '0;
        bus.cmd_s     = '0;
        bus.cmd_imm   = '0;
        bus.cmd_tag   = '0;
        bus.au_busy   = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_cleared("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reciprocal of 4.0 with R=1.0 -> 0.25
        model_lat = 2;
        model_res = 24'h001000;
        sb_push(24'h001000, 4'd3, 1'b0);
        send(OP_DIV, YSEL_RECIP, 24'h004000, 24'h010000, 24'h000123, 4'd3);
        wait_rsp(lat, st);
        check("recip_start_cycle", 32'(st), 32'd1);
        check("recip_latency", 32'(lat), 32'd4);
        check("recip_au_R", 32'(bus.au_R), 32'h004000);
        check("recip_au_S", 32'(bus.au_S), 32'h010000);
        check("recip_au_Iimm", 32'(bus.au_Iimm), 32'h000123);
        check("recip_au_op", 32'({bus.au_op_sel, bus.au_mul_y_sel}), 32'hE);
        wait_idle("recip");

        // Reciprocal of -2.0 -> -0.5, minimum latency
        model_lat = 1;
        model_res = 24'h802000;
        sb_push(24'h802000, 4'd4, 1'b0);
        send(OP_DIV, YSEL_RECIP, 24'h004000, 24'h808000, 24'h000000, 4'd4);
        wait_rsp(lat, st);
        check("negrecip_start_cycle", 32'(st), 32'd1);
        check("negrecip_min_latency", 32'(lat), 32'd3);
        wait_idle("negrecip");

        // Backpressure: response held 10 cycles, stray done and new command ignored
        bus.rsp_ready = 1'b0;
        model_lat     = 3;
        model_res     = 24'h00C000;
        sb_push(24'h00C000, 4'd9, 1'b0);
        send(2'b00, 2'b00, 24'h008000, 24'h004000, 24'h000000, 4'd9);
        wait_rsp(lat, st);
        check("bp_latency", 32'(lat), 32'd5);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            inj_done = (i == 3);
            inj_res  = 24'h7FFFFF;
            if (i == 0) begin
                bus.cmd_op    = 2'b01;
                bus.cmd_ysel  = 2'b01;
                bus.cmd_r     = 24'h010000;
                bus.cmd_s     = 24'h002000;
                bus.cmd_imm   = 24'h000040;
                bus.cmd_tag   = 4'd10;
                bus.cmd_valid = 1'b1;
            end
            @(negedge clk);
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_rsp_data", 32'(bus.rsp_data), 32'h00C000);
            check("bp_rsp_tag", 32'(bus.rsp_tag), 32'd9);
            check("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            check("bp_au_R_held", 32'(bus.au_R), 32'h008000);
        end
        @(posedge clk);
        #1;
        inj_done  = 1'b0;
        model_lat = 1;
        model_res = 24'h00A000;
        sb_push(24'h00A000, 4'd10, 1'b0);
        bus.rsp_ready = 1'b1;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (bus.cmd_ready) break;
        end
        check("bp_next_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        wait_idle("bp");
        check("bp_next_au_R_kept", 32'(bus.au_R), 32'h010000);
        check("bp_next_au_Iimm_kept", 32'(bus.au_Iimm), 32'h000040);

        // Timeout: AU never answers
        model_lat = 0;
        sb_push(24'h000000, 4'd5, 1'b1);
        send(2'b10, 2'b01, 24'h000100, 24'h000200, 24'h000300, 4'd5);
        wait_rsp(lat, st);
        check("timeout_start_cycle", 32'(st), 32'd1);
        check("timeout_cycles_after_wait", 32'(lat - 2), 32'd101);
        wait_idle("timeout");

        // Busy stall: no start while busy, exactly one after release
        bus.au_busy   = 1'b1;
        model_lat     = 2;
        model_res     = 24'h00E000;
        starts_before = start_cnt;
        sb_push(24'h00E000, 4'd6, 1'b0);
        send(2'b01, 2'b00, 24'h000400, 24'h000500, 24'h000600, 4'd6);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("busy_no_start", 32'(bus.au_start), 32'd0);
            check("busy_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.au_busy = 1'b0;
        wait_rsp(lat, st);
        check("busy_release_start", 32'(st), 32'd1);
        check("busy_release_latency", 32'(lat), 32'd4);
        wait_idle("busy");
        check("busy_start_count", 32'(start_cnt - starts_before), 32'd1);

        // Reset while in WAIT: everything cleared, pending response dropped
        model_lat = 0;
        send(2'b11, 2'b01, 24'h123456, 24'h00ABCD, 24'h0000FF, 4'd7);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_cleared("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_lat = 1;
        model_res = 24'h001234;
        sb_push(24'h001234, 4'd8, 1'b0);
        send(2'b00, 2'b10, 24'h000001, 24'h000002, 24'h000003, 4'd8);
        wait_rsp(lat, st);
        check("postreset_latency", 32'(lat), 32'd3);
        wait_idle("postreset");

        // Divide by -0 with negative R
        starts_before = start_cnt;
`ifdef AU_DRV_DIVZERO_CHECK_EN
        sb_push(24'hFFFFFF, 4'd12, 1'b1);
        send(OP_DIV, YSEL_RECIP, 24'h804000, 24'h800000, 24'h000000, 4'd12);
        wait_rsp(lat, st);
        check("divzero_latency", 32'(lat), 32'd1);
        wait_idle("divzero");
        repeat (3) @(negedge clk);
        check("divzero_no_start", 32'(start_cnt - starts_before), 32'd0);
`else
        model_lat = 2;
        model_res = 24'h7FFFFF;
        sb_push(24'h7FFFFF, 4'd12, 1'b0);
        send(OP_DIV, YSEL_RECIP, 24'h804000, 24'h800000, 24'h000000, 4'd12);
        wait_rsp(lat, st);
        check("divzero_fwd_latency", 32'(lat), 32'd4);
        wait_idle("divzero");
        check("divzero_fwd_start", 32'(start_cnt - starts_before), 32'd1);
`endif

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
